// File: rtl/sipo_8bit_rx.sv
// sipo_8bit_rx: MSB-first serial byte receiver feeding a DEPTH-entry valid/ready output FIFO.
// Define PARITY_CHECK_EN for a 9th even-parity bit per frame and the sticky perr flag.
module sipo_8bit_rx #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   si,
   input  logic                   si_vld,
   input  logic                   sync,
   output logic [7:0]             po,
   output logic                   po_vld,
   input  logic                   po_rdy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   ovf,
   output logic                   perr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
`ifdef PARITY_CHECK_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif
   localparam logic [3:0]       LAST_BIT = 4'(FRAME - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   // ---------------- frame assembly ----------------
   logic [7:0] r_shreg;
   logic [3:0] r_bcnt;
   logic [3:0] w_bcnt_nxt;
   logic       w_shift;
   logic       w_frame_end;
   logic       w_push_req;
   logic [7:0] w_push_byte;

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_bcnt_nxt  = r_bcnt;
      w_shift     = 1'b0;
      w_frame_end = 1'b0;
      if (sync) begin
         // A qualified bit on the sync edge is bit 0 of the new frame.
         w_bcnt_nxt = si_vld ? 4'd1 : 4'd0;
         w_shift    = si_vld;
      end else if (si_vld) begin
         if (r_bcnt == LAST_BIT) begin
            w_bcnt_nxt  = 4'd0;
            w_frame_end = 1'b1;
         end else begin
            w_bcnt_nxt = r_bcnt + 4'd1;
         end
`ifdef PARITY_CHECK_EN
         w_shift = (r_bcnt != LAST_BIT);
`else
         w_shift = 1'b1;
`endif
      end
   end

`ifdef PARITY_CHECK_EN
   logic w_par_err;
   logic r_perr;

   // Even parity: the parity bit must equal the XOR of the 8 data bits.
   assign w_par_err   = w_frame_end && (si != ^r_shreg);
   assign w_push_byte = r_shreg;
   assign w_push_req  = w_frame_end && !w_par_err;

   always_ff @(posedge clk) begin
      if (rst)            r_perr <= 1'b0;
      else if (w_par_err) r_perr <= 1'b1;
   end

   assign perr = r_perr;
`else
   logic w_unused_msb;

   // The MSB is shifted out on the completing edge and never read directly.
   assign w_unused_msb = r_shreg[7];
   assign w_push_byte  = {r_shreg[6:0], si};
   assign w_push_req   = w_frame_end;
   assign perr         = 1'b0;
`endif

   // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg <= 8'h00;
         r_bcnt  <= 4'd0;
      end else begin
         r_bcnt <= w_bcnt_nxt;
         if (w_shift) r_shreg <= {r_shreg[6:0], si};
      end
   end

   // ---------------- output FIFO ----------------
   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [LVL_W-1:0] r_level;
   logic             r_ovf;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   assign w_full = (r_level == FULL_LVL);
   assign w_pop  = po_vld && po_rdy;
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign w_push = w_push_req && (!w_full || w_pop);
   assign w_drop = w_push_req && w_full && !w_pop;

   // NOTE: storage has no reset; po is masked while empty, and rst clears the pointers that give it meaning.
   always_ff @(posedge clk) begin
      if (w_push && !rst) r_mem[r_wptr] <= w_push_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
         else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   assign po_vld = (r_level != '0);
   assign po     = po_vld ? r_mem[r_rptr] : 8'h00;
   assign level  = r_level;
   assign full   = w_full;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_sipo_8bit_rx.sv
// tb_sipo_8bit_rx: directed scenarios plus random traffic, checked every cycle against a
// bit-list / byte-queue reference model of the receiver.
module tb_sipo_8bit_rx;

   localparam int DEPTH = 4;
`ifdef PARITY_CHECK_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif

   logic       clk = 1'b0;
   logic       rst, si, si_vld, sync, po_rdy;
   logic [7:0] po;
   logic       po_vld, full, ovf, perr;
   logic [$clog2(DEPTH):0] level;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_fifo [$];
   bit         m_bits [$];
   bit         m_ovf, m_perr;

   sipo_8bit_rx #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .si(si), .si_vld(si_vld), .sync(sync),
      .po(po), .po_vld(po_vld), .po_rdy(po_rdy), .level(level),
      .full(full), .ovf(ovf), .perr(perr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: collect qualified bits into a list, form a byte when the frame is whole.
   task automatic model_edge(input bit r, input bit s, input bit sv, input bit sy, input bit rdy);
      bit         pop       = rdy && (m_fifo.size() != 0);
      bit         was_full  = (m_fifo.size() == DEPTH);
      bit         push_req  = 1'b0;
      int         b         = 0;
      int         ones      = 0;
      if (r) begin
         m_fifo.delete();
         m_bits.delete();
         m_ovf  = 1'b0;
         m_perr = 1'b0;
         return;
      end
      if (sy) begin
         m_bits.delete();
         if (sv) m_bits.push_back(s);
      end else if (sv) begin
         m_bits.push_back(s);
         if (m_bits.size() == FRAME) begin
            for (int i = 0; i < 8; i++) b = b * 2 + int'(m_bits[i]);
            for (int i = 0; i < FRAME; i++) ones += int'(m_bits[i]);
            m_bits.delete();
            if (FRAME == 8 || ones % 2 == 0) push_req = 1'b1;
            else m_perr = 1'b1;
         end
      end
      if (pop) void'(m_fifo.pop_front());
      if (push_req) begin
         if (was_full && !pop) m_ovf = 1'b1;
         else m_fifo.push_back(b[7:0]);
      end
   endtask

   task automatic check_outputs();
      check("po_vld", 32'(po_vld), 32'(m_fifo.size() != 0));
      check("level",  32'(level),  32'(m_fifo.size()));
      check("full",   32'(full),   32'(m_fifo.size() == DEPTH));
      check("ovf",    32'(ovf),    32'(m_ovf));
      check("perr",   32'(perr),   32'(m_perr));
      if (m_fifo.size() != 0) check("po", 32'(po), 32'(m_fifo[0]));
   endtask

   task automatic step(input bit r, input bit s, input bit sv, input bit sy, input bit rdy);
      rst = r; si = s; si_vld = sv; sync = sy; po_rdy = rdy;
      @(posedge clk);
      model_edge(r, s, sv, sy, rdy);
      #1;
      check_outputs();
   endtask

   // One frame MSB-first; parity bit (if any) appended, optionally corrupted.
   task automatic send_frame(input logic [7:0] b, input bit first_sync, input bit bad_par,
                             input bit rdy, input bit last_rdy, input bit gaps);
      logic [8:0] bits;
      bits = {b, (^b) ^ bad_par};
      for (int i = 0; i < FRAME; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) step(0, 1'($urandom_range(0, 1)), 0, 0, rdy);
         step(0, bits[8-i], 1, first_sync && i == 0, (i == FRAME - 1) ? last_rdy : rdy);
      end
   endtask

   initial begin
      logic [7:0] exp_drain [4];
      logic [6:0] tail;
      exp_drain = '{8'h02, 8'h03, 8'h04, 8'h66};

      // Reset state
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("rst_po", 32'(po), 32'h00);
      check("rst_vld", 32'(po_vld), 32'h0);
      check("rst_level", 32'(level), 32'h0);

      // Single byte with sync on bit 0, consumer ready
      send_frame(8'hA5, 1, 0, 1, 1, 0);
      check("a5_po", 32'(po), 32'hA5);
      check("a5_vld", 32'(po_vld), 32'h1);
      step(0, 0, 0, 0, 1);
      check("a5_drained", 32'(level), 32'h0);

      // Fill, overflow, then simultaneous push/pop while full
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 0, 0, 0, 0, 0);
         if (k == 4) check("full_after4", 32'(full), 32'h1);
      end
      check("ovf_after5", 32'(ovf), 32'h1);
      send_frame(8'h66, 0, 0, 0, 1, 0);
      check("pushpop_level", 32'(level), 32'h4);
      check("pushpop_ovf", 32'(ovf), 32'h1);
      for (int k = 0; k < 4; k++) begin
         check("drain_order", 32'(po), 32'(exp_drain[k]));
         step(0, 0, 0, 0, 1);
      end
      check("drain_ovf", 32'(ovf), 32'h1);

      // Reset mid-frame with two bytes queued
      send_frame(8'h11, 0, 0, 0, 0, 0);
      send_frame(8'h22, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      check("rstmid_vld", 32'(po_vld), 32'h0);
      check("rstmid_level", 32'(level), 32'h0);
      check("rstmid_ovf", 32'(ovf), 32'h0);
      send_frame(8'hC3, 0, 0, 0, 0, 0);
      check("c3_po", 32'(po), 32'hC3);
      step(0, 0, 0, 0, 1);

      // Partial frame abandoned by sync, rest of frame with gaps
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      tail = 7'b0111100;
      for (int i = 6; i >= 0; i--) begin
         if ($urandom_range(0, 1) == 1) step(0, 1, 0, 0, 0);
         step(0, tail[i], 1, 0, 0);
      end
      if (FRAME == 9) step(0, 0, 1, 0, 0);
      check("sync_po", 32'(po), 32'h3C);
      check("sync_level", 32'(level), 32'h1);
      step(0, 0, 0, 0, 1);

`ifdef PARITY_CHECK_EN
      send_frame(8'h5A, 0, 0, 0, 0, 0);
      check("par_good_level", 32'(level), 32'h1);
      check("par_good_perr", 32'(perr), 32'h0);
      send_frame(8'h5B, 0, 1, 0, 0, 0);
      check("par_bad_level", 32'(level), 32'h1);
      check("par_bad_perr", 32'(perr), 32'h1);
      step(0, 0, 0, 0, 1);
`endif

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 399) == 0,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
